// File: rtl/sync_fifo_ctrl.sv
// Control stage for a synchronous FIFO: drives a dual-port RAM's enables and addresses from push/pop.
// Flags and the rd_valid strobe are registered; a pop's RAM data is valid one cycle after the pop.
module sync_fifo_ctrl #(
  parameter int DEPTH     = 64,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] FULL_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_TH   = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AE_TH   = (AW+1)'(AEMPTY_TH);

  logic [AW:0] wptr, rptr;
  logic [AW:0] count_nxt;
  logic        wa, ra;

  // Acceptance uses the registered flags, so a full FIFO can still pop and an empty one still push.
  assign wa        = wr_en & ~full;
  assign ra        = rd_en & ~empty;
  assign ram_we    = wa;
  assign ram_re    = ra;
  assign ram_waddr = wptr[AW-1:0];
  assign ram_raddr = rptr[AW-1:0];

  always_comb begin
    count_nxt = count;
    case ({wa, ra})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      wptr         <= wptr + {{AW{1'b0}}, wa};
      rptr         <= rptr + {{AW{1'b0}}, ra};
      count        <= count_nxt;
      // Flags come from the next count so they line up with the count they describe.
      full         <= (count_nxt == FULL_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_TH);
      almost_empty <= (count_nxt <= AE_TH);
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
      rd_valid     <= ra;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl (DEPTH=8) with a behavioural RAM to check popped data order.
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en;
  logic          ram_we, ram_re, rd_valid;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  logic [7:0] mem [DEPTH];
  logic [7:0] wdata, rdata;

  int checks = 0;
  int passed = 0;

  sync_fifo_ctrl #(.DEPTH(DEPTH), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_re(ram_re), .ram_raddr(ram_raddr),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle registered read, as seen downstream of the controller.
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= wdata;
    if (ram_re) rdata <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input logic we, input logic re);
    wr_en = we;
    rd_en = re;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_pulses", 32'({overflow, underflow, rd_valid}), 0);
    chk("rst_ram_en", 32'({ram_we, ram_re}), 0);

    // Fill
    for (int i = 0; i < 8; i++) begin
      wdata = 8'hA0 + 8'(i);
      drive(1'b1, 1'b0);
      chk("fill_we", 32'(ram_we), 1);
      chk("fill_waddr", 32'(ram_waddr), 32'(i));
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 6));
      chk("fill_full", 32'(full), 32'(i + 1 == 8));
      chk("fill_aempty", 32'(almost_empty), 32'(i + 1 <= 2));
    end
    drive(1'b1, 1'b0);
    chk("ovf_we", 32'(ram_we), 0);
    tick();
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 8);
    drive(1'b0, 1'b0);
    tick();
    chk("ovf_once", 32'(overflow), 0);

    // Drain
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1);
      chk("drain_re", 32'(ram_re), 1);
      chk("drain_raddr", 32'(ram_raddr), 32'(i));
      tick();
      chk("drain_rdv", 32'(rd_valid), 1);
      chk("drain_data", 32'(rdata), 32'(8'hA0 + 8'(i)));
      chk("drain_count", 32'(count), 32'(7 - i));
      chk("drain_empty", 32'(empty), 32'(i == 7));
    end
    drive(1'b0, 1'b1);
    chk("udf_re", 32'(ram_re), 0);
    tick();
    chk("udf_pulse", 32'(underflow), 1);
    chk("udf_rdv", 32'(rd_valid), 0);
    chk("udf_count", 32'(count), 0);
    drive(1'b0, 1'b0);
    tick();
    chk("udf_once", 32'(underflow), 0);

    // Wrap-around: pointers start at 8 (low bits 0, wrap bit set)
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1);
      tick();
    end
    chk("wrap_msb_before", 32'(dut.wptr[AW]), 1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0);
      chk("wrap_waddr", 32'(ram_waddr), 32'((5 + i) % 8));
      tick();
    end
    chk("wrap_msb_after", 32'(dut.wptr[AW]), 0);
    chk("wrap_count", 32'(count), 6);
    chk("wrap_full", 32'(full), 0);

    // Simultaneous push/pop at count=3
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 1'b1);
    chk("mid_both_en", 32'({ram_we, ram_re}), 3);
    tick();
    chk("mid_count", 32'(count), 3);
    chk("mid_pulses", 32'({overflow, underflow}), 0);

    // Simultaneous when full
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    chk("full_reached", 32'(full), 1);
    drive(1'b1, 1'b1);
    chk("full_both_en", 32'({ram_we, ram_re}), 1);
    tick();
    chk("full_both_count", 32'(count), 7);
    chk("full_both_ovf", 32'(overflow), 1);
    chk("full_both_rdv", 32'(rd_valid), 1);

    // Simultaneous when empty
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1);
      tick();
    end
    chk("empty_reached", 32'(empty), 1);
    drive(1'b1, 1'b1);
    chk("empty_both_en", 32'({ram_we, ram_re}), 2);
    tick();
    chk("empty_both_count", 32'(count), 1);
    chk("empty_both_udf", 32'(underflow), 1);
    chk("empty_both_rdv", 32'(rd_valid), 0);

    // Reset mid-operation at count=5 with both requests active
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    chk("pre_rst_count", 32'(count), 5);
    rst = 1'b1;
    drive(1'b1, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_rdv", 32'(rd_valid), 0);
    chk("mrst_pulses", 32'({overflow, underflow}), 0);
    chk("mrst_ptrs", 32'({dut.wptr, dut.rptr}), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
